// File: rtl/decode_stage.sv
// Fetch/decode pipeline register with ARM-style field split, branch target and wrong-path squash.
// Latency: one cycle; backpressure: stall_i holds the register, ready_o = ~stall_i.
module decode_stage #(
    parameter int SQUASH_CYCLES = 1,
    parameter int PC_W          = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     inst_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic [PC_W-1:0] pc_o,
    output logic [3:0]      cond_o,
    output logic [2:0]      class_o,
    output logic [3:0]      opcode_o,
    output logic            set_flags_o,
    output logic [3:0]      rn_addr_o,
    output logic [3:0]      rd_addr_o,
    output logic [3:0]      rm_addr_o,
    output logic [11:0]     imm12_o,
    output logic            link_o,
    output logic [PC_W-1:0] branch_target_o,
    output logic            pc_write_o,
    output logic            undef_o
);

    localparam int CNT_W = (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SQUASH_CYCLES);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

    logic [31:0]     inst_q, inst_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [0:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
            state_d = ST_SQUASH;
            cnt_d   = CNT_LOAD;
        end else if (!stall_i) begin
            inst_d = inst_i;
            pc_d   = pc_i;
            // An exhausted counter (only reachable with zero squash slots) behaves as RUN.
            if (state_q == ST_RUN || cnt_q == '0) begin
                valid_d = valid_i;
                state_d = ST_RUN;
            end else begin
                valid_d = 1'b0;
                if (valid_i) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [PC_W-1:0] offset;

    always_comb begin
        offset = {{(PC_W-26){inst_q[23]}}, inst_q[23:0], 2'b00};
    end

    assign ready_o         = ~stall_i;
    assign valid_o         = valid_q;
    assign pc_o            = pc_q;
    assign cond_o          = inst_q[31:28];
    assign class_o         = inst_q[27:25];
    assign opcode_o        = inst_q[24:21];
    assign set_flags_o     = inst_q[20];
    assign rn_addr_o       = inst_q[19:16];
    assign rd_addr_o       = inst_q[15:12];
    assign rm_addr_o       = inst_q[3:0];
    assign imm12_o         = inst_q[11:0];
    assign branch_target_o = pc_q + PC_W'(8) + offset;
    assign link_o          = valid_q && (inst_q[27:25] == 3'b101) && inst_q[24];
    assign pc_write_o      = valid_q && (inst_q[15:12] == 4'hF) && !inst_q[27];
    assign undef_o         = valid_q && (inst_q[27:25] == 3'b011) && inst_q[4];

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field decode, branch target, flush/stall squash behaviour.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_i;
    logic [31:0] pc_i;
    logic        valid_i;
    logic        ready_o;
    logic        stall_i;
    logic        flush_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [3:0]  cond_o;
    logic [2:0]  class_o;
    logic [3:0]  opcode_o;
    logic        set_flags_o;
    logic [3:0]  rn_addr_o;
    logic [3:0]  rd_addr_o;
    logic [3:0]  rm_addr_o;
    logic [11:0] imm12_o;
    logic        link_o;
    logic [31:0] branch_target_o;
    logic        pc_write_o;
    logic        undef_o;

    int errors = 0;
    int checks = 0;

    decode_stage #(.SQUASH_CYCLES(1), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .pc_i(pc_i), .valid_i(valid_i),
        .ready_o(ready_o), .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o),
        .pc_o(pc_o), .cond_o(cond_o), .class_o(class_o), .opcode_o(opcode_o),
        .set_flags_o(set_flags_o), .rn_addr_o(rn_addr_o), .rd_addr_o(rd_addr_o),
        .rm_addr_o(rm_addr_o), .imm12_o(imm12_o), .link_o(link_o),
        .branch_target_o(branch_target_o), .pc_write_o(pc_write_o), .undef_o(undef_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic vld);
        inst_i  = inst;
        pc_i    = pc;
        valid_i = vld;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; inst_i = 32'hFFFF_FFFF; pc_i = 32'h1234; valid_i = 1'b1;
        stall_i = 1'b0; flush_i = 1'b0;
        step(); step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h want=0", pc_o); end
        checks++; if (cond_o !== 4'h0 || imm12_o !== 12'h0) begin errors++; $display("FAIL reset_fields got=%h/%h want=0/0", cond_o, imm12_o); end
        checks++; if (branch_target_o !== 32'h8) begin errors++; $display("FAIL reset_target got=%h want=8", branch_target_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready_o); end
        rst_n = 1'b1;
        valid_i = 1'b0;
        step();
    endtask

    task automatic test_alu_word();
        drive(32'hE281_1005, 32'h0, 1'b1);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL alu_valid got=%b want=1", valid_o); end
        checks++; if (cond_o !== 4'hE || class_o !== 3'b001 || opcode_o !== 4'b0100)
            begin errors++; $display("FAIL alu_cco got=%h/%b/%b want=e/001/0100", cond_o, class_o, opcode_o); end
        checks++; if (rn_addr_o !== 4'd1 || rd_addr_o !== 4'd1 || rm_addr_o !== 4'd5 || imm12_o !== 12'h005)
            begin errors++; $display("FAIL alu_regs got=%h/%h/%h/%h want=1/1/5/005", rn_addr_o, rd_addr_o, rm_addr_o, imm12_o); end
        checks++; if (set_flags_o !== 1'b0 || pc_write_o !== 1'b0 || link_o !== 1'b0 || undef_o !== 1'b0)
            begin errors++; $display("FAIL alu_flags got=%b%b%b%b want=0000", set_flags_o, pc_write_o, link_o, undef_o); end
    endtask

    task automatic test_branch();
        drive(32'hEA00_0002, 32'h10, 1'b1);
        checks++; if (branch_target_o !== 32'h20 || link_o !== 1'b0)
            begin errors++; $display("FAIL fwd_branch got=%h/%b want=20/0", branch_target_o, link_o); end
        drive(32'hEAFF_FFFE, 32'h40, 1'b1);
        checks++; if (branch_target_o !== 32'h40) begin errors++; $display("FAIL back_branch got=%h want=40", branch_target_o); end
        drive(32'hEB00_0000, 32'h100, 1'b1);
        checks++; if (branch_target_o !== 32'h108 || link_o !== 1'b1)
            begin errors++; $display("FAIL bl_branch got=%h/%b want=108/1", branch_target_o, link_o); end
        drive(32'hEA00_0000, 32'hFFFF_FFF8, 1'b1);
        checks++; if (branch_target_o !== 32'h0) begin errors++; $display("FAIL wrap_branch got=%h want=0", branch_target_o); end
        drive(32'hEB00_0000, 32'h100, 1'b0);
        checks++; if (link_o !== 1'b0 || branch_target_o !== 32'h108)
            begin errors++; $display("FAIL bl_invalid got=%b/%h want=0/108", link_o, branch_target_o); end
    endtask

    task automatic test_pc_write_undef();
        drive(32'hE1A0_F00E, 32'h200, 1'b1);
        checks++; if (rd_addr_o !== 4'hF || pc_write_o !== 1'b1)
            begin errors++; $display("FAIL pc_write got=%h/%b want=f/1", rd_addr_o, pc_write_o); end
        drive(32'hE1A0_F00E, 32'h204, 1'b0);
        checks++; if (rd_addr_o !== 4'hF || pc_write_o !== 1'b0 || valid_o !== 1'b0)
            begin errors++; $display("FAIL pc_write_invalid got=%h/%b/%b want=f/0/0", rd_addr_o, pc_write_o, valid_o); end
        drive(32'hE7F0_00F0, 32'h208, 1'b1);
        checks++; if (undef_o !== 1'b1 || class_o !== 3'b011)
            begin errors++; $display("FAIL undef got=%b/%b want=1/011", undef_o, class_o); end
        drive(32'hEA00_F000, 32'h20C, 1'b1);
        checks++; if (pc_write_o !== 1'b0 || undef_o !== 1'b0)
            begin errors++; $display("FAIL branch_rd15 got=%b/%b want=0/0", pc_write_o, undef_o); end
    endtask

    task automatic test_stall_hold();
        drive(32'hE281_1005, 32'h300, 1'b1);
        stall_i = 1'b1;
        drive(32'hEB00_0000, 32'h304, 1'b1);
        checks++; if (pc_o !== 32'h300 || valid_o !== 1'b1 || ready_o !== 1'b0 || imm12_o !== 12'h005)
            begin errors++; $display("FAIL stall_hold got=%h/%b/%b/%h want=300/1/0/005", pc_o, valid_o, ready_o, imm12_o); end
        stall_i = 1'b0;
    endtask

    task automatic test_flush();
        drive(32'hE281_1005, 32'h400, 1'b1);
        flush_i = 1'b1;
        drive(32'hE281_1005, 32'h404, 1'b1);
        flush_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || pc_o !== 32'h400)
            begin errors++; $display("FAIL flush_clear got=%b/%h want=0/400", valid_o, pc_o); end
        drive(32'hE281_1005, 32'h500, 1'b0);
        drive(32'hE281_1005, 32'hA00, 1'b1);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_discard_a got=%b want=0", valid_o); end
        drive(32'hE281_1005, 32'hB00, 1'b1);
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'hB00)
            begin errors++; $display("FAIL flush_accept_b got=%b/%h want=1/b00", valid_o, pc_o); end
    endtask

    task automatic test_flush_then_stall();
        flush_i = 1'b1;
        drive(32'h0, 32'h600, 1'b0);
        flush_i = 1'b0;
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) drive(32'hE281_1005, 32'hA10, 1'b1);
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b0)
            begin errors++; $display("FAIL squash_stall got=%b/%b want=0/0", valid_o, ready_o); end
        stall_i = 1'b0;
        drive(32'hE281_1005, 32'hA10, 1'b1);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stall_discard_a got=%b want=0", valid_o); end
        drive(32'hE281_1005, 32'hB10, 1'b1);
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'hB10)
            begin errors++; $display("FAIL stall_accept_b got=%b/%h want=1/b10", valid_o, pc_o); end
    endtask

    task automatic test_flush_during_stall();
        stall_i = 1'b1;
        flush_i = 1'b1;
        drive(32'hE281_1005, 32'h700, 1'b1);
        flush_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_in_stall got=%b want=0", valid_o); end
        stall_i = 1'b0;
        drive(32'hE281_1005, 32'hA20, 1'b1);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL fis_discard_a got=%b want=0", valid_o); end
        drive(32'hE281_1005, 32'hB20, 1'b1);
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'hB20)
            begin errors++; $display("FAIL fis_accept_b got=%b/%h want=1/b20", valid_o, pc_o); end
    endtask

    task automatic test_flush_reload();
        flush_i = 1'b1;
        drive(32'h0, 32'h800, 1'b1);
        drive(32'h0, 32'h804, 1'b1);
        flush_i = 1'b0;
        drive(32'hE281_1005, 32'hA30, 1'b1);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reload_discard got=%b want=0", valid_o); end
        drive(32'hE281_1005, 32'hB30, 1'b1);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL reload_accept got=%b want=1", valid_o); end
    endtask

    task automatic test_reset_mid_squash();
        flush_i = 1'b1;
        drive(32'h0, 32'h900, 1'b0);
        flush_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || pc_o !== 32'h0 || branch_target_o !== 32'h8)
            begin errors++; $display("FAIL async_reset got=%b/%h/%h want=0/0/8", valid_o, pc_o, branch_target_o); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'hE281_1005, 32'hC00, 1'b1);
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'hC00)
            begin errors++; $display("FAIL reset_exits_squash got=%b/%h want=1/c00", valid_o, pc_o); end
    endtask

    initial begin
        test_reset();
        test_alu_word();
        test_branch();
        test_pc_write_undef();
        test_stall_hold();
        test_flush();
        test_flush_then_stall();
        test_flush_during_stall();
        test_flush_reload();
        test_reset_mid_squash();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
